// File: rtl/if_id_stage_pkg.sv
// Shared Minisys-1A IF/ID definitions.
// Defines the default datapath width, the NOP encoding and the bit layout of the IF/ID bundle.
package if_id_stage_pkg;

  localparam int unsigned MINISYS_XLEN = 32;
  localparam logic [MINISYS_XLEN-1:0] MINISYS_NOP = 32'h0000_0000;  // sll $0,$0,0

  // Bundle layout, MSB first: {pc, pc4, instr, recover} = 97 bits
  localparam int unsigned BUNDLE_W    = 3 * MINISYS_XLEN + 1;
  localparam int unsigned PC_LSB      = 2 * MINISYS_XLEN + 1;
  localparam int unsigned PC4_LSB     = MINISYS_XLEN + 1;
  localparam int unsigned INSTR_LSB   = 1;
  localparam int unsigned RECOVER_BIT = 0;

endpackage

// File: rtl/if_id_stage_if.sv
// IF/ID handshake bundle.
// The master modport belongs to the fetch/decode environment; the slave modport belongs to the stage.
interface if_id_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] IF_PC;
  logic [XLEN-1:0] IF_opcplus4;
  logic [XLEN-1:0] IF_Instruction;
  logic            IF_recover;
  logic            if_valid;
  logic            if_ready;
  logic            ID_stall;
  logic            branch_flush;
  logic            int_flush;
  logic [XLEN-1:0] ID_PC;
  logic [XLEN-1:0] ID_opcplus4;
  logic [XLEN-1:0] ID_Instruction;
  logic            ID_recover;
  logic            ID_valid;

  modport master (
    output IF_PC, IF_opcplus4, IF_Instruction, IF_recover, if_valid,
    output ID_stall, branch_flush, int_flush,
    input  if_ready, ID_PC, ID_opcplus4, ID_Instruction, ID_recover, ID_valid
  );

  modport slave (
    input  IF_PC, IF_opcplus4, IF_Instruction, IF_recover, if_valid,
    input  ID_stall, branch_flush, int_flush,
    output if_ready, ID_PC, ID_opcplus4, ID_Instruction, ID_recover, ID_valid
  );
endinterface

// File: rtl/if_id_stage_pipe_slot.sv
// One pipeline register slot (data plus valid).
// Clear takes priority over load; data is left stale on clear.
module if_id_stage_pipe_slot #(
  parameter int unsigned Width = 97
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  output logic [Width-1:0] o_data
);

  logic             r_valid;
  logic [Width-1:0] r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline boundary: main slot plus one-entry skid slot, flush handling and a
// saturating counter of ID bubble cycles.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned     XLEN      = MINISYS_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = MINISYS_NOP,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  if_id_stage_if.slave     bus,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int unsigned BW = 3 * XLEN + 1;

  logic [BW-1:0] w_if_bundle;
  logic [BW-1:0] w_main_d;
  logic [BW-1:0] w_main_q;
  logic [BW-1:0] w_skid_q;
  logic          w_main_v;
  logic          w_skid_v;
  logic          w_main_vin;
  logic          w_main_load;
  logic          w_main_clear;
  logic          w_skid_load;
  logic          w_skid_clear;
  logic          w_acc;
  logic          w_adv;
  logic          w_flush;

  logic [CNT_W-1:0] r_bubble_count;

  assign w_if_bundle = {bus.IF_PC, bus.IF_opcplus4, bus.IF_Instruction, bus.IF_recover};

  // if_ready comes straight from the skid valid flop, so IF sees backpressure one cycle late
  assign bus.if_ready = ~w_skid_v;
  assign w_acc        = bus.if_valid & ~w_skid_v;
  assign w_adv        = ~w_main_v | ~bus.ID_stall;
  assign w_flush      = bus.int_flush | bus.branch_flush;

  always_comb begin
    w_main_clear = w_flush;
    w_main_load  = ~w_flush & w_adv;
    w_main_d     = w_skid_v ? w_skid_q : w_if_bundle;
    w_main_vin   = w_skid_v | w_acc;
    // Skid drains into main when it can advance; it only fills when main is stuck
    w_skid_clear = w_flush | (w_skid_v & w_adv);
    w_skid_load  = ~w_flush & ~w_skid_v & ~w_adv & w_acc;
  end

  if_id_stage_pipe_slot #(
    .Width (BW)
  ) u_main (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_valid (w_main_vin),
    .i_data  (w_main_d),
    .o_valid (w_main_v),
    .o_data  (w_main_q)
  );

  if_id_stage_pipe_slot #(
    .Width (BW)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_valid (1'b1),
    .i_data  (w_if_bundle),
    .o_valid (w_skid_v),
    .o_data  (w_skid_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bubble_count <= '0;
    end else if (!w_main_v && !(&r_bubble_count)) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign bubble_count       = r_bubble_count;
  assign bus.ID_valid       = w_main_v;
  assign bus.ID_PC          = w_main_q[BW-1 -: XLEN];
  assign bus.ID_opcplus4    = w_main_q[2*XLEN -: XLEN];
  assign bus.ID_Instruction = w_main_v ? w_main_q[XLEN:1] : NOP_INSTR;
  assign bus.ID_recover     = w_main_v & w_main_q[0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a scoreboard queue of expected words consumed by ID,
// plus point checks of handshake, flush, reset and bubble-counter behaviour.
module tb_if_id_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        rec;
  } word_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bubble_count;
  word_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  if_id_stage_if #(.XLEN(32)) bus ();

  if_id_stage #(
    .XLEN      (32),
    .NOP_INSTR (32'h0000_0000),
    .CNT_W     (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .bubble_count (bubble_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr, input logic rec,
                       input bit push);
    word_t w;
    bus.IF_PC          = pc;
    bus.IF_opcplus4    = pc + 32'd4;
    bus.IF_Instruction = instr;
    bus.IF_recover     = rec;
    bus.if_valid       = 1'b1;
    if (push) begin
      w.pc = pc; w.pc4 = pc + 32'd4; w.instr = instr; w.rec = rec;
      exp_q.push_back(w);
    end
  endtask

  // Monitor: a word is consumed by ID on the next edge when valid and not stalled
  always @(negedge clock) begin
    if (reset && bus.ID_valid && !bus.ID_stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word_pc", bus.ID_PC, 32'hxxxx_xxxx);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("sb_pc", bus.ID_PC, w.pc);
        check("sb_pc4", bus.ID_opcplus4, w.pc4);
        check("sb_instr", bus.ID_Instruction, w.instr);
        check("sb_recover", {31'd0, bus.ID_recover}, {31'd0, w.rec});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    bus.IF_PC = '0; bus.IF_opcplus4 = '0; bus.IF_Instruction = '0; bus.IF_recover = 1'b0;
    bus.if_valid = 1'b0; bus.ID_stall = 1'b0; bus.branch_flush = 1'b0; bus.int_flush = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, bus.ID_valid}, 32'd0);
    check("rst_instr", bus.ID_Instruction, 32'h0);
    check("rst_recover", {31'd0, bus.ID_recover}, 32'd0);
    check("rst_ready", {31'd0, bus.if_ready}, 32'd1);
    check("rst_bubble", {16'd0, bubble_count}, 32'd0);
    tick();
    tick();

    // Streaming, unstalled
    reset = 1'b1;
    offer(32'h0, 32'h0044_0820, 1'b0, 1'b1);
    tick();
    check("s1_valid", {31'd0, bus.ID_valid}, 32'd1);
    check("s1_pc0", bus.ID_PC, 32'h0);
    check("s1_bubble0", {16'd0, bubble_count}, 32'd1);
    offer(32'h4, 32'h0104_4022, 1'b0, 1'b1);
    tick();
    check("s1_pc4", bus.ID_PC, 32'h4);
    offer(32'h8, 32'h1500_fffe, 1'b0, 1'b1);
    tick();
    check("s1_pc8", bus.ID_PC, 32'h8);
    check("s1_bubble", {16'd0, bubble_count}, 32'd1);

    // Stall with skid fill, then release in order
    offer(32'h10, 32'h8c22_0000, 1'b0, 1'b1);
    tick();
    bus.ID_stall = 1'b1;
    offer(32'h14, 32'h0022_1820, 1'b0, 1'b1);
    tick();
    check("s2_ready_low", {31'd0, bus.if_ready}, 32'd0);
    check("s2_hold_pc", bus.ID_PC, 32'h10);
    offer(32'h18, 32'hac23_0004, 1'b0, 1'b1);
    tick();
    check("s2_ready_low2", {31'd0, bus.if_ready}, 32'd0);
    tick();
    check("s2_hold_pc2", bus.ID_PC, 32'h10);
    bus.ID_stall = 1'b0;
    tick();
    check("s2_pc14", bus.ID_PC, 32'h14);
    check("s2_ready_back", {31'd0, bus.if_ready}, 32'd1);
    tick();
    check("s2_pc18", bus.ID_PC, 32'h18);
    bus.if_valid = 1'b0;
    tick();
    check("s2_idle_valid", {31'd0, bus.ID_valid}, 32'd0);
    check("s2_idle_nop", bus.ID_Instruction, 32'h0);
    check("s2_stale_pc", bus.ID_PC, 32'h18);

    // Branch flush with skid occupied
    offer(32'h10, 32'h1022_0003, 1'b0, 1'b1);
    tick();
    bus.ID_stall = 1'b1;
    offer(32'h14, 32'h2021_0001, 1'b0, 1'b0);
    tick();
    check("s3_skid_full", {31'd0, bus.if_ready}, 32'd0);
    bus.ID_stall = 1'b0;
    bus.branch_flush = 1'b1;
    offer(32'h18, 32'h2042_0001, 1'b0, 1'b0);
    tick();
    check("s3_valid", {31'd0, bus.ID_valid}, 32'd0);
    check("s3_instr", bus.ID_Instruction, 32'h0);
    check("s3_ready", {31'd0, bus.if_ready}, 32'd1);
    bus.branch_flush = 1'b0;
    bus.if_valid = 1'b0;
    tick();

    // Interrupt + branch flush while stalled, then recovery word
    offer(32'h30, 32'h2063_0001, 1'b0, 1'b0);
    tick();
    bus.ID_stall = 1'b1;
    offer(32'h34, 32'h2084_0001, 1'b0, 1'b0);
    tick();
    bus.int_flush = 1'b1;
    bus.branch_flush = 1'b1;
    offer(32'h38, 32'h20a5_0001, 1'b0, 1'b0);
    tick();
    check("s4_valid", {31'd0, bus.ID_valid}, 32'd0);
    check("s4_ready", {31'd0, bus.if_ready}, 32'd1);
    bus.int_flush = 1'b0;
    bus.branch_flush = 1'b0;
    bus.ID_stall = 1'b0;
    offer(32'h0000_F000, 32'h401a_6800, 1'b1, 1'b1);
    tick();
    check("s4_int_pc", bus.ID_PC, 32'h0000_F000);
    check("s4_recover", {31'd0, bus.ID_recover}, 32'd1);
    bus.if_valid = 1'b0;
    tick();

    // Asynchronous reset mid-cycle with both slots full
    offer(32'h40, 32'h20c6_0001, 1'b1, 1'b0);
    tick();
    bus.ID_stall = 1'b1;
    offer(32'h44, 32'h20e7_0001, 1'b0, 1'b0);
    tick();
    check("s5_full", {31'd0, bus.if_ready}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("s5_valid", {31'd0, bus.ID_valid}, 32'd0);
    check("s5_instr", bus.ID_Instruction, 32'h0);
    check("s5_recover", {31'd0, bus.ID_recover}, 32'd0);
    check("s5_ready", {31'd0, bus.if_ready}, 32'd1);
    check("s5_bubble", {16'd0, bubble_count}, 32'd0);
    bus.ID_stall = 1'b0;
    bus.if_valid = 1'b0;
    tick();
    reset = 1'b1;

    // Bubble counter saturation
    repeat (65534) tick();
    check("s6_bubble_fffe", {16'd0, bubble_count}, 32'h0000_FFFE);
    tick();
    check("s6_bubble_sat", {16'd0, bubble_count}, 32'h0000_FFFF);
    repeat (6) tick();
    check("s6_bubble_hold", {16'd0, bubble_count}, 32'h0000_FFFF);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
